siso_burst_ctrl: RTL and testbench

Sequencer for a serial-in/serial-out shift lane, with the WIDTH-bit lane held internally. A single start request runs one burst:
- capture WIDTH bits from din,
- freeze the register for HOLD cycles,
- drain the captured bits first-in-first-out on dout,
- pulse done.

It sits between a frame-level requester and a serial link and provides busy/done handshaking around the shift datapath.

---
 rtl/siso_burst_ctrl_if.sv | 37 +++
 rtl/siso_burst_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_siso_burst_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/siso_burst_ctrl_if.sv
// siso_burst_ctrl_if
//   Handshake/bus bundle between a frame-level requester and siso_burst_ctrl.
//
//   Requester -> controller : start, din (and abort when SISO_BURST_ABORT_EN
//                             is defined)
//   Controller -> requester : dout, out_valid, shift_en, busy, done, state[1:0]
//
//   Modports:
//     master : the requester / link side (drives start, din, abort)
//     slave  : the burst controller
//
//   Build option: SISO_BURST_ABORT_EN adds the abort request line.
interface siso_burst_ctrl_if;
  logic       start;
  logic       din;
`ifdef SISO_BURST_ABORT_EN
  logic       abort;
`endif
  logic       dout;
  logic       out_valid;
  logic       shift_en;
  logic       busy;
  logic       done;
  logic [1:0] state;

`ifdef SISO_BURST_ABORT_EN
  modport master (output start, din, abort,
                  input  dout, out_valid, shift_en, busy, done, state);
  modport slave  (input  start, din, abort,
                  output dout, out_valid, shift_en, busy, done, state);
`else
  modport master (output start, din,
                  input  dout, out_valid, shift_en, busy, done, state);
  modport slave  (input  start, din,
                  output dout, out_valid, shift_en, busy, done, state);
`endif
endinterface

// File: rtl/siso_burst_ctrl.sv
// siso_burst_ctrl
//   Burst sequencer around a WIDTH-bit serial-in/serial-out shift lane.
//   One accepted start runs: capture WIDTH bits from din, freeze for HOLD
//   cycles, drain the captured bits first-in-first-out on dout, pulse done.
//
//   Parameters:
//     WIDTH : lane length in bits (2..255)
//     HOLD  : hold window in clock cycles (1..255)
//
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-low reset
//     bus : siso_burst_ctrl_if.slave
//             start     in  burst request, only looked at in IDLE
//             din       in  serial data, taken on SHIFT_IN edges
//             abort     in  (SISO_BURST_ABORT_EN only) cancel a running burst
//             dout      out sreg[WIDTH-1]
//             out_valid out high while draining
//             shift_en  out high while the lane shifts (capture or drain)
//             busy      out high in every state but IDLE
//             done      out one-cycle end-of-burst pulse
//             state     out IDLE=0 SHIFT_IN=1 HOLD=2 SHIFT_OUT=3 (DONE reads 0)
//
//   Build option: define SISO_BURST_ABORT_EN to enable the abort input.
//   All outputs come from registers or decoded registered state.
module siso_burst_ctrl #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 4
) (
  input logic              clk,
  input logic              rst,
  siso_burst_ctrl_if.slave bus
);

  localparam int CNT_MAX = (WIDTH > HOLD) ? WIDTH : HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_HOLD,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sreg_reg, sreg_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic             abort_hit;
  logic             shift_fill;
  logic [WIDTH-1:0] sreg_shifted;

  logic       out_valid_dec;
  logic       shift_en_dec;
  logic       busy_dec;
  logic       done_dec;
  logic [1:0] state_code;

`ifdef SISO_BURST_ABORT_EN
  assign abort_hit = bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Capture shifts din in at the bottom; drain shifts zeros in, which is
  // why the lane is all-zero again once a burst completes.
  assign shift_fill      = (state_reg == S_SHIFT_IN) ? bus.din : 1'b0;
  assign sreg_shifted[0] = shift_fill;

  generate
    genvar gi;
    for (gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign sreg_shifted[gi] = sreg_reg[gi-1];
    end
  endgenerate

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      sreg_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sreg_reg  <= sreg_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_next = state_reg;
    sreg_next  = sreg_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_SHIFT_IN;
          cnt_next   = '0;
        end
      end
      S_SHIFT_IN: begin
        sreg_next = sreg_shifted;
        if (cnt_reg == W_LAST) begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_reg == H_LAST) begin
          state_next = S_SHIFT_OUT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_SHIFT_OUT: begin
        sreg_next = sreg_shifted;
        if (cnt_reg == W_LAST) begin
          state_next = S_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        // start seen here is dropped, not queued
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort overrides every other transition, but only mid-burst
    if (abort_hit && ((state_reg == S_SHIFT_IN) ||
                      (state_reg == S_HOLD) ||
                      (state_reg == S_SHIFT_OUT))) begin
      state_next = S_IDLE;
      sreg_next  = '0;
      cnt_next   = '0;
    end
  end

  // Output decode from registered state
  always_comb begin
    out_valid_dec = 1'b0;
    shift_en_dec  = 1'b0;
    busy_dec      = 1'b1;
    done_dec      = 1'b0;
    state_code    = 2'd0;

    case (state_reg)
      S_IDLE: begin
        busy_dec = 1'b0;
      end
      S_SHIFT_IN: begin
        shift_en_dec = 1'b1;
        state_code   = 2'd1;
      end
      S_HOLD: begin
        state_code = 2'd2;
      end
      S_SHIFT_OUT: begin
        shift_en_dec  = 1'b1;
        out_valid_dec = 1'b1;
        state_code    = 2'd3;
      end
      S_DONE: begin
        // DONE is reported as code 0, distinguished by done
        done_dec = 1'b1;
      end
      default: begin
        busy_dec = 1'b0;
      end
    endcase
  end

  assign bus.dout      = sreg_reg[WIDTH-1];
  assign bus.out_valid = out_valid_dec;
  assign bus.shift_en  = shift_en_dec;
  assign bus.busy      = busy_dec;
  assign bus.done      = done_dec;
  assign bus.state     = state_code;

endmodule

// File: tb/tb_siso_burst_ctrl.sv
// tb_siso_burst_ctrl
//   Two controllers: A with default WIDTH=4/HOLD=4 and B with WIDTH=2/HOLD=1.
//   A burst-level model (cycle offset since acceptance plus captured bits)
//   predicts every output on every falling edge; directed scenarios add
//   literal checks of latency, busy length and drained bit order.
module tb_siso_burst_ctrl;
  localparam int WA = 4;
  localparam int HA = 4;
  localparam int WB = 2;
  localparam int HB = 1;

  typedef struct packed {
    logic [1:0] state;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic       shift_en;
    logic       dout;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;

  siso_burst_ctrl_if ifa ();
  siso_burst_ctrl_if ifb ();

  siso_burst_ctrl #(.WIDTH(WA), .HOLD(HA)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  siso_burst_ctrl #(.WIDTH(WB), .HOLD(HB)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  logic abort_a, abort_b;
`ifdef SISO_BURST_ABORT_EN
  assign abort_a = ifa.abort;
  assign abort_b = ifb.abort;
`else
  assign abort_a = 1'b0;
  assign abort_b = 1'b0;
`endif

  outs_t act_a, act_b;
  assign act_a = {ifa.state, ifa.busy, ifa.done, ifa.out_valid, ifa.shift_en, ifa.dout};
  assign act_b = {ifb.state, ifb.busy, ifb.done, ifb.out_valid, ifb.shift_en, ifb.dout};

  // ---------------- behavioural model ----------------
  // t = cycles since the accepting edge (-1 when idle). The burst timeline is
  // w capture cycles, h hold cycles, w drain cycles, then one done cycle.
  // The lane starts each burst empty, so dout is 0 while capturing, shows
  // the first captured bit throughout the hold, then bit j on drain cycle j.
  function automatic outs_t model_outs(input int t, input int w, input int h,
                                       input logic [255:0] bits);
    outs_t o;
    o = '0;
    if (t >= 0) begin
      o.busy = 1'b1;
      if (t < w) begin
        o.state = 2'd1; o.shift_en = 1'b1;
      end else if (t < w + h) begin
        o.state = 2'd2; o.dout = bits[0];
      end else if (t < 2 * w + h) begin
        o.state = 2'd3; o.out_valid = 1'b1; o.shift_en = 1'b1;
        o.dout = bits[8'(t - w - h)];
      end else begin
        o.done = 1'b1;
      end
    end
    return o;
  endfunction

  int ta = -1;
  int tb = -1;
  logic [255:0] bits_a = '0;
  logic [255:0] bits_b = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) ta <= -1;
    else if (ta < 0) begin
      if (ifa.start) ta <= 0;
    end else if ((abort_a && ta < 2 * WA + HA) || ta == 2 * WA + HA) ta <= -1;
    else begin
      if (ta < WA) bits_a[8'(ta)] <= ifa.din;
      ta <= ta + 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) tb <= -1;
    else if (tb < 0) begin
      if (ifb.start) tb <= 0;
    end else if ((abort_b && tb < 2 * WB + HB) || tb == 2 * WB + HB) tb <= -1;
    else begin
      if (tb < WB) bits_b[8'(tb)] <= ifb.din;
      tb <= tb + 1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check_outs(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %b required %b (state,busy,done,out_valid,shift_en,dout)",
               name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check_outs("cycle_a", act_a, model_outs(ta, WA, HA, bits_a));
    check_outs("cycle_b", act_b, model_outs(tb, WB, HB, bits_b));
  end

  // ---------------- burst monitors ----------------
  int   start_edge_a = 0, busy_len_a = 0, lat_a = 0, blen_a = 0;
  int   done_cnt_a = 0, done_edge_a = 0, prev_done_edge_a = 0;
  logic busy_prev_a = 1'b0;
  logic [7:0] seq_a = '0;

  always @(negedge clk) begin
    busy_prev_a <= ifa.busy;
    if (ifa.busy && !busy_prev_a) begin
      start_edge_a <= edge_cnt; busy_len_a <= 1; seq_a <= '0;
    end else if (ifa.busy) busy_len_a <= busy_len_a + 1;
    if (ifa.out_valid) seq_a <= {seq_a[6:0], ifa.dout};
    if (ifa.done) begin
      lat_a <= edge_cnt - start_edge_a;
      blen_a <= busy_len_a + 1;
      done_cnt_a <= done_cnt_a + 1;
      prev_done_edge_a <= done_edge_a;
      done_edge_a <= edge_cnt;
    end
  end

  int   start_edge_b = 0, busy_len_b = 0, lat_b = 0, blen_b = 0, done_cnt_b = 0;
  logic busy_prev_b = 1'b0;
  logic [7:0] seq_b = '0;

  always @(negedge clk) begin
    busy_prev_b <= ifb.busy;
    if (ifb.busy && !busy_prev_b) begin
      start_edge_b <= edge_cnt; busy_len_b <= 1; seq_b <= '0;
    end else if (ifb.busy) busy_len_b <= busy_len_b + 1;
    if (ifb.out_valid) seq_b <= {seq_b[6:0], ifb.dout};
    if (ifb.done) begin
      lat_b <= edge_cnt - start_edge_b;
      blen_b <= busy_len_b + 1;
      done_cnt_b <= done_cnt_b + 1;
    end
  end

  // ---------------- stimulus ----------------
  // pat is sent MSB first: pat[W-1] is the first din bit.
  task automatic burst_a(input logic [7:0] pat);
    @(negedge clk); ifa.start = 1'b1;
    @(negedge clk); ifa.start = 1'b0; ifa.din = pat[WA-1];
    for (int i = WA - 2; i >= 0; i--) begin @(negedge clk); ifa.din = pat[i]; end
    @(negedge clk); ifa.din = 1'b0;
  endtask

  task automatic burst_b(input logic [7:0] pat);
    @(negedge clk); ifb.start = 1'b1;
    @(negedge clk); ifb.start = 1'b0; ifb.din = pat[WB-1];
    for (int i = WB - 2; i >= 0; i--) begin @(negedge clk); ifb.din = pat[i]; end
    @(negedge clk); ifb.din = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int n0, k;
    n0 = done_cnt_a; k = 0;
    while (done_cnt_a == n0 && k < budget) begin @(negedge clk); #1; k++; end
    check_int("done_seen_a", done_cnt_a - n0, 1);
  endtask

  task automatic wait_done_b(input int budget);
    int n0, k;
    n0 = done_cnt_b; k = 0;
    while (done_cnt_b == n0 && k < budget) begin @(negedge clk); #1; k++; end
    check_int("done_seen_b", done_cnt_b - n0, 1);
  endtask

  task automatic check_burst_a(input string name, input logic [3:0] exp_seq);
    check_int({name, "_latency"}, lat_a, 12);
    check_int({name, "_busy_cycles"}, blen_a, 13);
    check_int({name, "_dout_seq"}, int'(seq_a[3:0]), int'(exp_seq));
    $display("burst A %s: latency=%0d busy=%0d dout_seq=%b", name, lat_a, blen_a, seq_a[3:0]);
  endtask

  task automatic check_burst_b(input string name, input logic [1:0] exp_seq);
    check_int({name, "_latency"}, lat_b, 5);
    check_int({name, "_busy_cycles"}, blen_b, 6);
    check_int({name, "_dout_seq"}, int'(seq_b[1:0]), int'(exp_seq));
    $display("burst B %s: latency=%0d busy=%0d dout_seq=%b", name, lat_b, blen_b, seq_b[1:0]);
  endtask

  initial begin
    int d0;
    ifa.start = 1'b0; ifa.din = 1'b0;
    ifb.start = 1'b0; ifb.din = 1'b0;
`ifdef SISO_BURST_ABORT_EN
    ifa.abort = 1'b0; ifb.abort = 1'b0;
`endif

    // Reset, then a quiet idle stretch
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      check_outs("idle_a", act_a, '0);
    end

    // Basic burst 1,1,0,1
    burst_a(8'b0000_1101);
    wait_done_a(40);
    check_burst_a("basic", 4'b1101);
    check_int("model_bits_a", int'(bits_a[3:0]), 4'b1011);

    burst_a(8'b0000_0110);
    wait_done_a(40);
    check_burst_a("pattern_0110", 4'b0110);

    // start held through bursts and DONE: one burst per IDLE entry
    d0 = done_cnt_a;
    @(negedge clk); ifa.start = 1'b1;
    for (int i = 0; i < 30; i++) begin @(negedge clk); ifa.din = (i % 3 == 0); end
    ifa.start = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check_int("held_start_bursts", done_cnt_a - d0, 3);
    check_int("held_start_done_gap", done_edge_a - prev_done_edge_a, 14);
    $display("held start: bursts=%0d done_gap=%0d", done_cnt_a - d0, done_edge_a - prev_done_edge_a);

    // Asynchronous reset in the middle of HOLD
    burst_a(8'b0000_1111);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check_outs("async_rst_a", act_a, '0);
    d0 = done_cnt_a;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_int("no_done_after_rst", done_cnt_a - d0, 0);
    burst_a(8'b0000_1101);
    wait_done_a(40);
    check_burst_a("post_rst", 4'b1101);

    // Small corner: WIDTH=2, HOLD=1
    burst_b(8'b0000_0001);
    wait_done_b(20);
    check_burst_b("corner_01", 2'b01);
    burst_b(8'b0000_0010);
    wait_done_b(20);
    check_burst_b("corner_10", 2'b10);

`ifdef SISO_BURST_ABORT_EN
    // Abort on the second drain cycle
    d0 = done_cnt_a;
    burst_a(8'b0000_1011);
    repeat (5) @(negedge clk);
    ifa.abort = 1'b1;
    @(negedge clk); ifa.abort = 1'b0;
    #1;
    check_outs("abort_a", act_a, '0);
    repeat (20) @(negedge clk);
    #1;
    check_int("no_done_after_abort", done_cnt_a - d0, 0);
    $display("abort: dones_after_abort=%0d", done_cnt_a - d0);

    // Abort alongside start in IDLE does not block the burst
    @(negedge clk); ifa.start = 1'b1; ifa.abort = 1'b1;
    @(negedge clk); ifa.start = 1'b0; ifa.abort = 1'b0;
    #1;
    check_int("abort_in_idle_busy", int'(ifa.busy), 1);
    wait_done_a(40);
    check_burst_a("after_idle_abort", 4'b0000);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
